// File: rtl/dmem_resp_if.sv
// DMEM port and console TX byte stream between the mina core side and dmem_resp.
interface dmem_resp_if;
  typedef logic [31:0] u32_t;
  typedef logic [3:0]  wrstb_t;

  u32_t       dmem_addr;
  u32_t       dmem_wrdata;
  wrstb_t     dmem_wrstb;
  u32_t       dmem_rddata;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       bus_err;

  modport master (
    output dmem_addr, dmem_wrdata, dmem_wrstb, tx_ready,
    input  dmem_rddata, tx_data, tx_valid, bus_err
  );

  modport slave (
    input  dmem_addr, dmem_wrdata, dmem_wrstb, tx_ready,
    output dmem_rddata, tx_data, tx_valid, bus_err
  );
endinterface

// File: rtl/dmem_resp.sv
// DMEM target for mina: word RAM, console TX FIFO and cycle counter MMIO.
// Define MINA_DMEM_CYCCNT_EN to build the 64-bit cycle counter (CYC_LO/CYC_HI).
module dmem_resp #(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  dmem_resp_if.slave  bus
);
  localparam int unsigned AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]   ram [RAM_WORDS];
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          overflow;
  logic          bus_err_q;
  logic [63:0]   cyc_val;

  logic          ram_hit, mmio_hit, wr_any;
  logic [1:0]    reg_sel;
  logic [AW-1:0] word_idx;
  logic          full, empty, pop, push_req, push_ok, ovf_clr, err_wr;
  logic [31:0]   stat_word;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^bus.dmem_addr[1:0];

  assign ram_hit  = bus.dmem_addr < RAM_BYTES;
  assign mmio_hit = bus.dmem_addr[31:4] == 28'hF000_000;
  assign reg_sel  = bus.dmem_addr[3:2];
  assign word_idx = bus.dmem_addr[AW+1:2];
  assign wr_any   = |bus.dmem_wrstb;

  assign empty    = count == '0;
  assign full     = count == CW'(FIFO_DEPTH);
  assign pop      = !empty && bus.tx_ready;
  assign push_req = mmio_hit && reg_sel == 2'd0 && bus.dmem_wrstb[0];
  // A full FIFO still takes the byte when the head leaves on the same edge.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_clr  = mmio_hit && reg_sel == 2'd1 && bus.dmem_wrstb[0] && bus.dmem_wrdata[2];
  assign err_wr   = wr_any && (!(ram_hit || mmio_hit) || (mmio_hit && reg_sel[1]));

  assign stat_word = {16'h0000, 8'(count), 5'b00000, overflow, empty, full};

  always_ff @(posedge clk) begin
    if (ram_hit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (bus.dmem_wrstb[i]) ram[word_idx][8*i +: 8] <= bus.dmem_wrdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.dmem_wrdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
      bus_err_q <= err_wr;
    end
  end

`ifdef MINA_DMEM_CYCCNT_EN
  logic [63:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (rst) cyc_cnt <= '0;
    else     cyc_cnt <= cyc_cnt + 64'd1;
  end

  assign cyc_val = cyc_cnt;
`else
  assign cyc_val = '0;
`endif

  always_comb begin
    bus.dmem_rddata = '0;
    if (ram_hit) begin
      bus.dmem_rddata = ram[word_idx];
    end else if (mmio_hit) begin
      unique case (reg_sel)
        2'd1:    bus.dmem_rddata = stat_word;
        2'd2:    bus.dmem_rddata = cyc_val[31:0];
        2'd3:    bus.dmem_rddata = cyc_val[63:32];
        default: bus.dmem_rddata = '0;
      endcase
    end
  end

  // Head byte is gated so the stream idles at zero whenever the FIFO is empty.
  assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
  assign bus.tx_valid = !empty;
  assign bus.bus_err  = bus_err_q;
endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp; TX bytes are tracked by a scoreboard queue.
module tb_dmem_resp;
  localparam int unsigned RAM_WORDS = 4096;
  localparam int unsigned DEPTH     = 8;
  localparam logic [31:0] CONS_DATA = 32'hF000_0000;
  localparam logic [31:0] CONS_STAT = 32'hF000_0004;
  localparam logic [31:0] CYC_LO    = 32'hF000_0008;
  localparam logic [31:0] CYC_HI    = 32'hF000_000C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic        model_ovf = 1'b0;
  logic [31:0] ram10;

  dmem_resp_if bus();

  dmem_resp #(.RAM_WORDS(RAM_WORDS), .FIFO_DEPTH(DEPTH), .INIT_FILE("")) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Scoreboard consumer: checks valid against the model and pops on each handshake.
  always @(negedge clk) begin : mon
    logic [7:0] head;
    if (!rst) begin
      checks++;
      if (bus.tx_valid !== (exp_q.size() != 0)) begin
        failures++;
        $display("FAIL tx_valid: got %b expected %b", bus.tx_valid, exp_q.size() != 0);
      end
      if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1 && exp_q.size() != 0) begin
        head = exp_q.pop_front();
        checks++;
        if (bus.tx_data !== head) begin
          failures++;
          $display("FAIL tx_pop: got %h expected %h", bus.tx_data, head);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.dmem_addr   = a;
    bus.dmem_wrdata = d;
    bus.dmem_wrstb  = s;
    step();
    bus.dmem_wrstb  = 4'h0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.dmem_addr  = a;
    bus.dmem_wrstb = 4'h0;
    #1;
    d = bus.dmem_rddata;
  endtask

  task automatic push(input logic [7:0] b);
    logic pop_now, accept;
    pop_now = bus.tx_ready && exp_q.size() != 0;
    accept  = exp_q.size() < DEPTH || pop_now;
    wr(CONS_DATA, {24'h0, b}, 4'b0001);
    if (accept) exp_q.push_back(b);
    else        model_ovf = 1'b1;
  endtask

  function automatic logic [31:0] exp_stat();
    int unsigned n;
    n = exp_q.size();
    return {16'h0000, 8'(n), 5'b00000, model_ovf, n == 0, n == DEPTH};
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    bus.dmem_addr = '0; bus.dmem_wrdata = '0; bus.dmem_wrstb = '0; bus.tx_ready = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL rst_tx_valid: got %b expected 0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data: got %h expected 00", bus.tx_data); end
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL rst_bus_err: got %b expected 0", bus.bus_err); end
    rd(CONS_STAT, d);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL rst_stat: got %h expected 00000002", d); end
    rst = 1'b0;
    rd(CONS_STAT, d);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL post_rst_stat: got %h expected 00000002", d); end
    rd(CYC_LO, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL post_rst_cyc_lo: got %h expected 0", d); end
    rd(CYC_HI, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL post_rst_cyc_hi: got %h expected 0", d); end
  endtask

  task automatic test_ram_lanes();
    logic [31:0] d;
    wr(32'h10, 32'hAABB_CCDD, 4'b1111);
    wr(32'h10, 32'h1122_3344, 4'b0101);
    rd(32'h10, d);
    checks++; if (d !== 32'hAA22_CC44) begin failures++; $display("FAIL ram_lanes: got %h expected aa22cc44", d); end
    rd(32'h13, d);
    checks++; if (d !== 32'hAA22_CC44) begin failures++; $display("FAIL ram_lsb_ignored: got %h expected aa22cc44", d); end
    bus.dmem_addr = 32'h10; bus.dmem_wrdata = 32'h0F0F_0F0F; bus.dmem_wrstb = 4'hF;
    #1;
    checks++; if (bus.dmem_rddata !== 32'hAA22_CC44) begin failures++; $display("FAIL ram_read_old: got %h expected aa22cc44", bus.dmem_rddata); end
    step();
    bus.dmem_wrstb = 4'h0;
    ram10 = 32'h0F0F_0F0F;
    rd(32'h10, d);
    checks++; if (d !== ram10) begin failures++; $display("FAIL ram_rewrite: got %h expected %h", d, ram10); end
    wr(RAM_WORDS * 4 - 4, 32'hCAFE_F00D, 4'hF);
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL ram_top_err: got %b expected 0", bus.bus_err); end
    rd(RAM_WORDS * 4 - 4, d);
    checks++; if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL ram_top: got %h expected cafef00d", d); end
    wr(RAM_WORDS * 4, 32'h1234_5678, 4'hF);
    checks++; if (bus.bus_err !== 1'b1) begin failures++; $display("FAIL ram_end_err: got %b expected 1", bus.bus_err); end
    rd(RAM_WORDS * 4, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL ram_end_read: got %h expected 0", d); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) push(8'h41 + 8'(i));
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL push_err: got %b expected 0", bus.bus_err); end
    rd(CONS_STAT, d);
    checks++; if (d !== 32'h0000_0805 || d !== exp_stat()) begin failures++; $display("FAIL stat_full: got %h expected %h", d, exp_stat()); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (bus.tx_data !== 8'h41) begin failures++; $display("FAIL tx_hold: got %h expected 41", bus.tx_data); end
      step();
    end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drain_ovf: got %0d left expected 0", exp_q.size()); end
    bus.tx_ready = 1'b0;
    step();
    rd(CONS_STAT, d);
    checks++; if (d !== exp_stat()) begin failures++; $display("FAIL stat_drained: got %h expected %h", d, exp_stat()); end
    wr(CONS_STAT, 32'h4, 4'b0010);
    rd(CONS_STAT, d);
    checks++; if (d !== 32'h0000_0006) begin failures++; $display("FAIL w1c_nostrobe: got %h expected 00000006", d); end
    wr(CONS_STAT, 32'h4, 4'b0001);
    model_ovf = 1'b0;
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL w1c_err: got %b expected 0", bus.bus_err); end
    rd(CONS_STAT, d);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL w1c: got %h expected 00000002", d); end
    wr(CONS_DATA, 32'h77, 4'b0010);
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL data_nostrobe_err: got %b expected 0", bus.bus_err); end
    rd(CONS_STAT, d);
    checks++; if (d !== exp_stat()) begin failures++; $display("FAIL data_nostrobe: got %h expected %h", d, exp_stat()); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    bus.tx_ready = 1'b1;
    push(8'h58);
    bus.tx_ready = 1'b0;
    rd(CONS_STAT, d);
    checks++; if (d !== 32'h0000_0801 || d !== exp_stat()) begin failures++; $display("FAIL full_push_pop: got %h expected %h", d, exp_stat()); end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drain_full: got %0d left expected 0", exp_q.size()); end
    bus.tx_ready = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.tx_ready = 1'b1;
    push(8'h70);
    checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h70) begin failures++; $display("FAIL empty_push_pop: got %b/%h expected 1/70", bus.tx_valid, bus.tx_data); end
    push(8'h71);
    push(8'h72);
    for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drain_b2b: got %0d left expected 0", exp_q.size()); end
    bus.tx_ready = 1'b0;
    step();
  endtask

  task automatic test_errors();
    logic [31:0] d, v;
    wr(32'h0, 32'h5A5A_1234, 4'hF);
    bus.dmem_addr = 32'h8000_0000; bus.dmem_wrdata = 32'hDEAD_BEEF; bus.dmem_wrstb = 4'hF;
    #1;
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL err_early: got %b expected 0", bus.bus_err); end
    step();
    bus.dmem_wrstb = 4'h0;
    checks++; if (bus.bus_err !== 1'b1) begin failures++; $display("FAIL err_unmapped: got %b expected 1", bus.bus_err); end
    step();
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL err_one_cycle: got %b expected 0", bus.bus_err); end
    rd(32'h0, d);
    checks++; if (d !== 32'h5A5A_1234) begin failures++; $display("FAIL err_ram_kept: got %h expected 5a5a1234", d); end
    rd(32'h8000_0000, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL unmapped_read: got %h expected 0", d); end
    step();
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL read_no_err: got %b expected 0", bus.bus_err); end
    rd(CYC_LO, v);
    wr(CYC_LO, 32'hFFFF_FFFF, 4'hF);
    checks++; if (bus.bus_err !== 1'b1) begin failures++; $display("FAIL err_cyc_lo: got %b expected 1", bus.bus_err); end
    step();
    checks++; if (bus.bus_err !== 1'b0) begin failures++; $display("FAIL err_cyc_one_cycle: got %b expected 0", bus.bus_err); end
    rd(CYC_LO, d);
`ifdef MINA_DMEM_CYCCNT_EN
    checks++; if (d !== v + 32'd2) begin failures++; $display("FAIL cyc_unaltered: got %h expected %h", d, v + 32'd2); end
`else
    checks++; if (d !== 32'h0 || v !== 32'h0) begin failures++; $display("FAIL cyc_unaltered: got %h/%h expected 0", v, d); end
`endif
    wr(32'hF000_0010, 32'h1, 4'b0001);
    checks++; if (bus.bus_err !== 1'b1) begin failures++; $display("FAIL err_mmio_hole: got %b expected 1", bus.bus_err); end
    step();
  endtask

  task automatic test_counter();
    logic [31:0] d;
`ifdef MINA_DMEM_CYCCNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (100) step();
    rd(CYC_LO, d);
    checks++; if (d !== 32'd100) begin failures++; $display("FAIL cyc_100: got %0d expected 100", d); end
    force dut.cyc_cnt = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cyc_cnt;
    step();
    rd(CYC_LO, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL cyc_carry_lo: got %h expected 0", d); end
    rd(CYC_HI, d);
    checks++; if (d !== 32'h1) begin failures++; $display("FAIL cyc_carry_hi: got %h expected 1", d); end
`else
    repeat (20) step();
    rd(CYC_LO, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL cyc_lo_off: got %h expected 0", d); end
    rd(CYC_HI, d);
    checks++; if (d !== 32'h0) begin failures++; $display("FAIL cyc_hi_off: got %h expected 0", d); end
`endif
    step();
  endtask

  task automatic test_reset_midstream();
    logic [31:0] d;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'h61 + 8'(i));
    checks++; if (bus.tx_valid !== 1'b1) begin failures++; $display("FAIL queued_valid: got %b expected 1", bus.tx_valid); end
    rst = 1'b1;
    step();
    exp_q.delete();
    model_ovf = 1'b0;
    checks++; if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin failures++; $display("FAIL flush: got %b/%h expected 0/00", bus.tx_valid, bus.tx_data); end
    rst = 1'b0;
    rd(CONS_STAT, d);
    checks++; if (d !== 32'h0000_0002) begin failures++; $display("FAIL flush_stat: got %h expected 00000002", d); end
    rd(32'h10, d);
    checks++; if (d !== ram10) begin failures++; $display("FAIL ram_survives_rst: got %h expected %h", d, ram10); end
    step();
  endtask

  initial begin
    test_reset();
    test_ram_lanes();
    test_fifo_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_errors();
    test_counter();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
